// File: rtl/mem_arbiter.sv
// Two-client (icache/dcache) memory arbiter with round-robin tie-break, burst-holding grants,
// and an outstanding-read counter that steers returning data to the issuing owner.
module mem_arbiter #(
    parameter int unsigned CNT_W = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    // icache
    input  logic        i_ren,
    input  logic        i_wen,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    output logic        i_gnt,
    output logic        i_valid,
    output logic [15:0] i_rdata,
    // dcache
    input  logic        d_ren,
    input  logic        d_wen,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [15:0] d_rdata,
    // memory
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_data_valid,
    // status
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {StIdle, StGntI, StGntD, StDrain} state_t;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    // Owner / last-served encoding: 0 = icache, 1 = dcache.
    state_t           r_state, w_state_d;
    logic             r_owner, w_owner_d;
    logic             r_last, w_last_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic             r_err, w_err_d;

    logic w_i_req, w_d_req, w_cnt_nz, w_dv_ok, w_rd_issue;

    assign w_i_req    = i_ren | i_wen;
    assign w_d_req    = d_ren | d_wen;
    assign w_cnt_nz   = |r_cnt;
    assign w_dv_ok    = mem_data_valid & w_cnt_nz;
    assign w_rd_issue = mem_ren & ~mem_wen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_owner <= w_owner_d;
            r_last  <= w_last_d;
            r_cnt   <= w_cnt_d;
            r_err   <= w_err_d;
        end
    end

    // Memory command path: only the granted client reaches memory.
    always_comb begin
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (r_state)
            StGntI: begin
                i_gnt     = 1'b1;
                mem_ren   = w_i_req;
                mem_wen   = i_wen;
                mem_addr  = i_addr;
                mem_wdata = i_wdata;
            end
            StGntD: begin
                d_gnt     = 1'b1;
                mem_ren   = w_d_req;
                mem_wen   = d_wen;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end
            default: ;
        endcase
    end

    // Read data goes to the owner only while its transaction is live.
    assign i_valid = w_dv_ok & ~r_owner & ((r_state == StGntI) | (r_state == StDrain));
    assign d_valid = w_dv_ok &  r_owner & ((r_state == StGntD) | (r_state == StDrain));
    assign i_rdata = i_valid ? mem_rdata : 16'h0000;
    assign d_rdata = d_valid ? mem_rdata : 16'h0000;

    assign busy = (r_state != StIdle);
    assign err  = r_err;

    // Outstanding-read counter; saturates at all-ones and ignores stray valids, both flagged in err.
    always_comb begin
        w_cnt_d = r_cnt;
        w_err_d = r_err;
        if (mem_data_valid && !w_cnt_nz) begin
            w_err_d = 1'b1;
        end
        if (w_rd_issue && !w_dv_ok) begin
            if (r_cnt == CntMax) begin
                w_err_d = 1'b1;
            end else begin
                w_cnt_d = r_cnt + CntOne;
            end
        end else if (!w_rd_issue && w_dv_ok) begin
            w_cnt_d = r_cnt - CntOne;
        end
    end

    // Exit decisions use the post-edge count so the last return retires the transaction at once.
    always_comb begin
        w_state_d = r_state;
        w_owner_d = r_owner;
        w_last_d  = r_last;
        unique case (r_state)
            StIdle: begin
                if (w_i_req && w_d_req) begin
                    w_state_d = r_last ? StGntI : StGntD;
                    w_owner_d = ~r_last;
                end else if (w_i_req) begin
                    w_state_d = StGntI;
                    w_owner_d = 1'b0;
                end else if (w_d_req) begin
                    w_state_d = StGntD;
                    w_owner_d = 1'b1;
                end
            end
            StGntI: begin
                if (!w_i_req) begin
                    w_last_d  = 1'b0;
                    w_state_d = (w_cnt_d != '0) ? StDrain : StIdle;
                end
            end
            StGntD: begin
                if (!w_d_req) begin
                    w_last_d  = 1'b1;
                    w_state_d = (w_cnt_d != '0) ? StDrain : StIdle;
                end
            end
            StDrain: begin
                if (w_cnt_d == '0) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed multi-cycle sequences and
// randomized traffic against a transaction-level reference model with a latency-queue memory.
module tb_mem_arbiter;

    localparam int CMAX = 7;

    logic        clk, rst_n;
    logic        i_ren, i_wen, d_ren, d_wen;
    logic [15:0] i_addr, i_wdata, d_addr, d_wdata;
    logic        i_gnt, i_valid, d_gnt, d_valid;
    logic [15:0] i_rdata, d_rdata;
    logic        mem_ren, mem_wen, mem_data_valid, busy, err;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    mem_arbiter #(.CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_ren(i_ren), .i_wen(i_wen), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Output vector layout: i_gnt[71] d_gnt[70] mem_ren[69] mem_wen[68] mem_addr[67:52]
    // mem_wdata[51:36] i_valid[35] i_rdata[34:19] d_valid[18] d_rdata[17:2] busy[1] err[0]
    function automatic logic [71:0] outs();
        return {i_gnt, d_gnt, mem_ren, mem_wen, mem_addr, mem_wdata,
                i_valid, i_rdata, d_valid, d_rdata, busy, err};
    endfunction

    function automatic logic [71:0] mk(input logic ig, input logic dg, input logic mr,
                                       input logic mw, input logic [15:0] ma,
                                       input logic [15:0] mwd, input logic iv,
                                       input logic [15:0] ird, input logic dv,
                                       input logic [15:0] drd, input logic bsy, input logic er);
        return {ig, dg, mr, mw, ma, mwd, iv, ird, dv, drd, bsy, er};
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rdf(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [15:0] data;
    } resp_t;

    resp_t       resp_q[$];
    int          cyc = 0;
    int          lat_min = 1, lat_max = 1;
    int          m_hold;   // -1 free, 0 icache, 1 dcache
    bit          m_gnt;    // holder currently granted (else draining)
    int          m_pend;
    logic        m_err;
    int          m_last;
    logic [71:0] obs;

    task automatic model_reset(input bit keep_q);
        m_hold = -1;
        m_gnt  = 0;
        m_pend = 0;
        m_err  = 1'b0;
        m_last = 1;
        if (!keep_q) resp_q.delete();
    endtask

    task automatic drive_zero();
        i_ren = 0; i_wen = 0; i_addr = 0; i_wdata = 0;
        d_ren = 0; d_wen = 0; d_addr = 0; d_wdata = 0;
        mem_data_valid = 0; mem_rdata = 0;
    endtask

    task automatic do_reset(input bit keep_q);
        rst_n = 1'b0;
        #1;
        i_ren = 1; d_ren = 1; mem_data_valid = 1; mem_rdata = 16'hFFFF;
        #1;
        check("rst_outs_zero", outs(), '0);
        drive_zero();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset(keep_q);
    endtask

    // One clock of stimulus; the memory responder and reference model supply expectations.
    task automatic drive_cycle(input logic ir, input logic iw, input logic [15:0] ia,
                               input logic [15:0] iwd, input logic dr, input logic dw,
                               input logic [15:0] da, input logic [15:0] dwd, input logic spur);
        logic        mdv, eg_i, eg_d, emr, emw, ev_i, ev_d, dv_ok, rd, ireq, dreq, hreq;
        logic [15:0] mrd, ea, ewd;
        int          np;
        resp_t       r;
        mdv = 0;
        mrd = 0;
        if (resp_q.size() != 0 && resp_q[0].due <= cyc) begin
            r   = resp_q.pop_front();
            mdv = 1;
            mrd = r.data;
        end else if (spur) begin
            mdv = 1;
            mrd = 16'($urandom);
        end
        i_ren = ir; i_wen = iw; i_addr = ia; i_wdata = iwd;
        d_ren = dr; d_wen = dw; d_addr = da; d_wdata = dwd;
        mem_data_valid = mdv; mem_rdata = mrd;

        ireq = ir | iw;
        dreq = dr | dw;
        eg_i = m_gnt && m_hold == 0;
        eg_d = m_gnt && m_hold == 1;
        emr = 0; emw = 0; ea = 0; ewd = 0;
        if (eg_i) begin emr = ireq; emw = iw; ea = ia; ewd = iwd; end
        if (eg_d) begin emr = dreq; emw = dw; ea = da; ewd = dwd; end
        dv_ok = mdv && m_pend > 0;
        ev_i  = dv_ok && m_hold == 0;
        ev_d  = dv_ok && m_hold == 1;

        @(negedge clk);
        obs = outs();
        check($sformatf("cycle%0d", cyc), obs,
              {eg_i, eg_d, emr, emw, ea, ewd, ev_i, ev_i ? mrd : 16'h0,
               ev_d, ev_d ? mrd : 16'h0, m_hold >= 0, m_err});

        @(posedge clk);
        rd = emr && !emw;
        np = m_pend + (rd ? 1 : 0) - (dv_ok ? 1 : 0);
        if (mdv && m_pend == 0) m_err = 1'b1;
        if (np > CMAX) begin
            np    = CMAX;
            m_err = 1'b1;
        end
        if (rd) resp_q.push_back('{due: cyc + int'($urandom_range(lat_max, lat_min)),
                                   data: rdf(ea)});
        hreq = (m_hold == 0) ? ireq : dreq;
        if (m_hold < 0) begin
            if (ireq && dreq) m_hold = (m_last == 1) ? 0 : 1;
            else if (ireq)    m_hold = 0;
            else if (dreq)    m_hold = 1;
            m_gnt = (m_hold >= 0);
        end else if (m_gnt) begin
            if (!hreq) begin
                m_last = m_hold;
                m_gnt  = 0;
                if (np == 0) m_hold = -1;
            end
        end else if (np == 0) begin
            m_hold = -1;
        end
        m_pend = np;
        cyc++;
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        ir, iw;
        logic [15:0] ia, iwd;
        logic        dr, dw;
        logic [15:0] da, dwd;
        logic        mdv;
        logic [15:0] mrd;
        logic [71:0] exp;
    } vec_t;

    function automatic vec_t row(input logic ir, input logic iw, input logic [15:0] ia,
                                 input logic [15:0] iwd, input logic dr, input logic dw,
                                 input logic [15:0] da, input logic [15:0] dwd,
                                 input logic mdv, input logic [15:0] mrd,
                                 input logic [71:0] exp);
        vec_t v;
        v.ir = ir; v.iw = iw; v.ia = ia; v.iwd = iwd;
        v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
        v.mdv = mdv; v.mrd = mrd; v.exp = exp;
        return v;
    endfunction

    vec_t tbl[14];

    initial begin
        logic [15:0] a;
        int          nv, ndv, first_k, winner;
        bit          ion, don;
        int          r;
        logic        ir, iw, dr, dw;

        // idle -> dcache write -> icache read with drain -> dcache read -> stray valid
        tbl[0]  = row(0, 0, 0, 0, 0, 1, 16'h2000, 16'hBEEF, 0, 0, '0);
        tbl[1]  = row(0, 0, 0, 0, 0, 1, 16'h2000, 16'hBEEF, 0, 0,
                      mk(0, 1, 1, 1, 16'h2000, 16'hBEEF, 0, 0, 0, 0, 1, 0));
        tbl[2]  = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl[3]  = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        tbl[4]  = row(1, 0, 16'h0100, 0, 0, 0, 0, 0, 0, 0, '0);
        tbl[5]  = row(1, 0, 16'h0100, 0, 0, 0, 0, 0, 0, 0,
                      mk(1, 0, 1, 0, 16'h0100, 0, 0, 0, 0, 0, 1, 0));
        tbl[6]  = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl[7]  = row(0, 0, 0, 0, 1, 0, 16'h3000, 0, 1, 16'h1234,
                      mk(0, 0, 0, 0, 0, 0, 1, 16'h1234, 0, 0, 1, 0));
        tbl[8]  = row(0, 0, 0, 0, 1, 0, 16'h3000, 0, 0, 0, '0);
        tbl[9]  = row(0, 0, 0, 0, 1, 0, 16'h3000, 0, 0, 0,
                      mk(0, 1, 1, 0, 16'h3000, 0, 0, 0, 0, 0, 1, 0));
        tbl[10] = row(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hCAFE,
                      mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 16'hCAFE, 1, 0));
        tbl[11] = row(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h7777, '0);
        tbl[12] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl[13] = row(1, 0, 16'h0200, 0, 0, 0, 0, 0, 1, 16'h5555,
                      mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        rst_n = 1'b1;
        drive_zero();
        #1;
        do_reset(0);

        for (int k = 0; k < 14; k++) begin
            i_ren = tbl[k].ir; i_wen = tbl[k].iw; i_addr = tbl[k].ia; i_wdata = tbl[k].iwd;
            d_ren = tbl[k].dr; d_wen = tbl[k].dw; d_addr = tbl[k].da; d_wdata = tbl[k].dwd;
            mem_data_valid = tbl[k].mdv; mem_rdata = tbl[k].mrd;
            @(negedge clk);
            check($sformatf("vec%0d", k), outs(), tbl[k].exp);
            @(posedge clk);
            #1;
        end
        // sticky err clears only through reset (state is GNT_I here, so reset must be async)
        do_reset(0);
        check("err_cleared", 72'(err), 72'(0));

        // both requesting from release, 4 reads, icache drops, drain, then dcache
        lat_min = 8; lat_max = 8;
        drive_cycle(1, 0, 0, 0, 1, 0, 16'h3000, 0, 0);
        for (int k = 0; k < 4; k++) begin
            a = 16'h0500 + 16'(2 * k);
            drive_cycle(1, 0, a, 0, 1, 0, 16'h3000, 0, 0);
            if (k == 0) check("tie_first_icache", 72'(obs[71:70]), 72'(2'b10));
        end
        nv = 0;
        first_k = -1;
        for (int k = 0; k < 12; k++) begin
            drive_cycle(0, 0, 0, 0, 1, 0, 16'h3000, 0, 0);
            if (obs[35]) nv++;
            if (obs[70] && first_k < 0) first_k = k;
        end
        check("drain_valid_count", 72'(nv), 72'(4));
        check("drain_then_dgnt", 72'(first_k), 72'(9));

        // 8-word icache burst with memory latency 4
        do_reset(0);
        lat_min = 4; lat_max = 4;
        nv = 0;
        ndv = 0;
        for (int k = 0; k < 17; k++) begin
            a = 16'h0100 + 16'(2 * (k - 1));
            if (k >= 1 && k <= 8) drive_cycle(1, 0, a, 0, 0, 0, 0, 0, 0);
            else if (k == 0)      drive_cycle(1, 0, 16'h0100, 0, 0, 0, 0, 0, 0);
            else                  drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (obs[35]) begin
                check("burst_data", 72'(obs[34:19]), 72'(rdf(16'h0100 + 16'(2 * nv))));
                nv++;
            end
            if (obs[18]) ndv++;
        end
        check("burst_ivalid_count", 72'(nv), 72'(8));
        check("burst_no_dvalid", 72'(ndv), 72'(0));
        check("burst_end_idle_noerr", 72'(obs[1:0]), 72'(0));

        // reset mid-burst with 3 reads outstanding; late returns become stray valids
        do_reset(0);
        lat_min = 10; lat_max = 10;
        drive_cycle(1, 0, 16'h0400, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) drive_cycle(1, 0, 16'h0400 + 16'(2 * k), 0, 0, 0, 0, 0, 0);
        i_ren = 1;
        #1;
        check("gnt_before_rst", 72'({i_gnt, mem_ren, busy}), 72'(3'b111));
        do_reset(1);
        for (int k = 0; k < 12; k++) begin
            drive_cycle(0, 1, 16'h0600, 16'h1111, 0, 1, 16'h0700, 16'h2222, 0);
            if (k == 1) check("tie_after_rst", 72'(obs[71:70]), 72'(2'b10));
        end
        check("stale_valid_err", 72'({obs[35], obs[18], obs[0]}), 72'(3'b001));

        // alternating contention: grants I, D, I, D
        do_reset(0);
        lat_min = 1; lat_max = 1;
        for (int t = 0; t < 4; t++) begin
            drive_cycle(0, 1, 16'h0010, 16'h00AA, 0, 1, 16'h0020, 16'h00BB, 0);
            drive_cycle(0, 1, 16'h0010, 16'h00AA, 0, 1, 16'h0020, 16'h00BB, 0);
            winner = obs[71] ? 0 : (obs[70] ? 1 : 2);
            check($sformatf("rr_order%0d", t), 72'(winner), 72'(t % 2));
            drive_cycle(0, winner != 0, 16'h0010, 16'h00AA, 0, winner != 1, 16'h0020,
                        16'h00BB, 0);
        end

        // randomized traffic with variable latency and rare stray valids
        do_reset(0);
        lat_min = 1; lat_max = 6;
        ion = 0;
        don = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(3) == 0) ion = !ion;
            if ($urandom_range(3) == 0) don = !don;
            r  = int'($urandom_range(4));
            ir = ion && (r != 0);
            iw = ion && (r <= 1);
            r  = int'($urandom_range(4));
            dr = don && (r != 0);
            dw = don && (r <= 1);
            drive_cycle(ir, iw, 16'($urandom), 16'($urandom), dr, dw, 16'($urandom),
                        16'($urandom), $urandom_range(499) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
